// File: rtl/img_pipe_reg_slave_if.sv
// CPU register bus between a host master and the image-pipe register slave.
// Writes and reads complete with a one-cycle wack or rdv strobe.
interface img_pipe_reg_slave_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          reg_cpu_cs;
    logic [AW-1:0] reg_cpu_addr;
    logic [DW-1:0] reg_cpu_data_wr;
    logic          reg_cpu_we;
    logic          reg_cpu_re;
    logic          reg_cpu_wack;
    logic          reg_cpu_rdv;
    logic [DW-1:0] reg_cpu_data_rd;

    modport master (
        output reg_cpu_cs, reg_cpu_addr, reg_cpu_data_wr, reg_cpu_we, reg_cpu_re,
        input  reg_cpu_wack, reg_cpu_rdv, reg_cpu_data_rd
    );

    modport slave (
        input  reg_cpu_cs, reg_cpu_addr, reg_cpu_data_wr, reg_cpu_we, reg_cpu_re,
        output reg_cpu_wack, reg_cpu_rdv, reg_cpu_data_rd
    );
endinterface

// File: rtl/img_pipe_reg_slave.sv
// Register slave for the image pipeline: config, status/irq and frame counter.
// Writes ack one cycle after the request; reads return data two cycles after it.
module img_pipe_reg_slave #(
    parameter int          DW     = 32,
    parameter int          AW     = 32,
    parameter logic [31:0] ID_VAL = 32'h1A6E_0001
) (
    input  logic                 reg_cpu_clk,
    input  logic                 rst,
    img_pipe_reg_slave_if.slave  bus,
    input  logic                 pipe_busy,
    input  logic                 pipe_done,
    output logic                 cfg_enable,
    output logic                 cfg_start,
    output logic [11:0]          cfg_width,
    output logic [11:0]          cfg_height,
    output logic [7:0]           cfg_thresh,
    output logic                 irq
);

    localparam logic [7:0] A_ID     = 8'h00;
    localparam logic [7:0] A_CTRL   = 8'h04;
    localparam logic [7:0] A_SIZE   = 8'h08;
    localparam logic [7:0] A_THRESH = 8'h0C;
    localparam logic [7:0] A_STATUS = 8'h10;
    localparam logic [7:0] A_IRQ_EN = 8'h14;
    localparam logic [7:0] A_FCNT   = 8'h18;

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_VALID} state_t;

    state_t        state, state_nxt;
    logic          wr_fire, rd_fire;
    logic [7:0]    wsel;
    logic [DW-1:0] wdata;
    logic [7:0]    rd_addr_q;
    logic [DW-1:0] rd_mux, rd_q;
    logic          done, irq_en;
    logic [15:0]   frame_cnt;
    logic          unused_bits;

    assign wsel    = bus.reg_cpu_addr[7:0];
    assign wdata   = bus.reg_cpu_data_wr;
    // A request with both strobes is a write; anything outside IDLE is dropped.
    assign wr_fire = (state == IDLE) && bus.reg_cpu_cs && bus.reg_cpu_we;
    assign rd_fire = (state == IDLE) && bus.reg_cpu_cs && bus.reg_cpu_re && !bus.reg_cpu_we;

    assign unused_bits = ^{bus.reg_cpu_addr[AW-1:8], wdata};

    always_ff @(posedge reg_cpu_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.reg_cpu_wack = 1'b0;
        bus.reg_cpu_rdv  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_fire)      state_nxt = WR_ACK;
                else if (rd_fire) state_nxt = RD_WAIT;
            end
            WR_ACK: begin
                bus.reg_cpu_wack = 1'b1;
                state_nxt        = IDLE;
            end
            RD_WAIT:  state_nxt = RD_VALID;
            RD_VALID: begin
                bus.reg_cpu_rdv = 1'b1;
                state_nxt       = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    assign bus.reg_cpu_data_rd = bus.reg_cpu_rdv ? rd_q : '0;

    always_comb begin
        rd_mux = '0;
        case (rd_addr_q)
            A_ID:     rd_mux[31:0]  = ID_VAL;
            A_CTRL:   rd_mux[0]     = cfg_enable;
            A_SIZE: begin
                rd_mux[11:0]  = cfg_width;
                rd_mux[27:16] = cfg_height;
            end
            A_THRESH: rd_mux[7:0]   = cfg_thresh;
            A_STATUS: rd_mux[1:0]   = {done, pipe_busy};
            A_IRQ_EN: rd_mux[0]     = irq_en;
            A_FCNT:   rd_mux[15:0]  = frame_cnt;
            default:  rd_mux        = '0;
        endcase
    end

    // Read data is captured at the end of RD_WAIT, freezing live status bits.
    always_ff @(posedge reg_cpu_clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_q      <= '0;
        end else begin
            if (rd_fire)            rd_addr_q <= wsel;
            if (state == RD_WAIT)   rd_q      <= rd_mux;
        end
    end

    always_ff @(posedge reg_cpu_clk or posedge rst) begin
        if (rst) begin
            cfg_enable <= 1'b0;
            cfg_start  <= 1'b0;
            cfg_width  <= 12'd640;
            cfg_height <= 12'd480;
            cfg_thresh <= 8'h80;
            irq_en     <= 1'b0;
        end else begin
            cfg_start <= wr_fire && (wsel == A_CTRL) && wdata[1];
            if (wr_fire) begin
                case (wsel)
                    A_CTRL:   cfg_enable <= wdata[0];
                    A_SIZE: begin
                        cfg_width  <= wdata[11:0];
                        cfg_height <= wdata[27:16];
                    end
                    A_THRESH: cfg_thresh <= wdata[7:0];
                    A_IRQ_EN: irq_en     <= wdata[0];
                    default:  ;
                endcase
            end
        end
    end

    // A frame-done pulse beats a same-cycle W1C, and a counter write that
    // coincides with a pulse leaves the count at 1.
    always_ff @(posedge reg_cpu_clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            frame_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            if (pipe_done)
                done <= 1'b1;
            else if (wr_fire && (wsel == A_STATUS) && wdata[1])
                done <= 1'b0;

            if (wr_fire && (wsel == A_FCNT))
                frame_cnt <= pipe_done ? 16'd1 : 16'd0;
            else if (pipe_done)
                frame_cnt <= frame_cnt + 16'd1;

            irq <= done & irq_en;
        end
    end

endmodule

// File: tb/tb_img_pipe_reg_slave.sv
// Bench for img_pipe_reg_slave: table of register accesses plus hand sequences,
// with read data checked through an expected-value queue.
module tb_img_pipe_reg_slave;

    localparam logic [31:0] ID = 32'h1A6E_0001;

    logic        reg_cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_busy = 1'b0;
    logic        pipe_done = 1'b0;
    logic        cfg_enable, cfg_start, irq;
    logic [11:0] cfg_width, cfg_height;
    logic [7:0]  cfg_thresh;

    img_pipe_reg_slave_if #(.DW(32), .AW(32)) bus ();

    img_pipe_reg_slave #(.DW(32), .AW(32), .ID_VAL(ID)) dut (
        .reg_cpu_clk (reg_cpu_clk),
        .rst         (rst),
        .bus         (bus),
        .pipe_busy   (pipe_busy),
        .pipe_done   (pipe_done),
        .cfg_enable  (cfg_enable),
        .cfg_start   (cfg_start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_thresh  (cfg_thresh),
        .irq         (irq)
    );

    always #5 reg_cpu_clk = ~reg_cpu_clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          w_first, w_cnt, s_cnt, r_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic wait_rdv(input string nm);
        int n = 0;
        bit got = 0;
        logic [31:0] exp;
        while (!got && n < 8) begin
            @(negedge reg_cpu_clk);
            n++;
            if (bus.reg_cpu_rdv) got = 1;
            else chk({nm, "_rdzero"}, bus.reg_cpu_data_rd, 32'h0);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no rdv within %0d cycles", nm, n);
        end else begin
            chk({nm, "_lat"}, n, 2);
            chk(nm, bus.reg_cpu_data_rd, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        sb.push_back(exp);
        @(negedge reg_cpu_clk);
        bus.reg_cpu_cs = 1; bus.reg_cpu_re = 1; bus.reg_cpu_we = 0; bus.reg_cpu_addr = a;
        @(posedge reg_cpu_clk);
        #1 bus.reg_cpu_cs = 0; bus.reg_cpu_re = 0;
        wait_rdv(nm);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic dn, input logic also_re);
        @(negedge reg_cpu_clk);
        bus.reg_cpu_cs = 1; bus.reg_cpu_we = 1; bus.reg_cpu_re = also_re;
        bus.reg_cpu_addr = a; bus.reg_cpu_data_wr = d; pipe_done = dn;
        @(posedge reg_cpu_clk);
        #1 bus.reg_cpu_cs = 0; bus.reg_cpu_we = 0; bus.reg_cpu_re = 0; pipe_done = 0;
        w_first = 0; w_cnt = 0; s_cnt = 0; r_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge reg_cpu_clk);
            if (i == 0) w_first = int'(bus.reg_cpu_wack);
            w_cnt += int'(bus.reg_cpu_wack);
            s_cnt += int'(cfg_start);
            r_cnt += int'(bus.reg_cpu_rdv);
        end
    endtask

    task automatic chk_wack(input string nm);
        chk({nm, "_wack_lat"}, w_first, 1);
        chk({nm, "_wack_cnt"}, w_cnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reg_cpu_cs = 0; bus.reg_cpu_we = 0; bus.reg_cpu_re = 0;
        bus.reg_cpu_addr = '0; bus.reg_cpu_data_wr = '0;

        tbl.push_back('{0, 32'h00, 32'h0, ID});
        tbl.push_back('{0, 32'h04, 32'h0, 32'h0});
        tbl.push_back('{0, 32'h08, 32'h0, 32'h01E0_0280});
        tbl.push_back('{0, 32'h0C, 32'h0, 32'h80});
        tbl.push_back('{0, 32'h10, 32'h0, 32'h0});
        tbl.push_back('{0, 32'h14, 32'h0, 32'h0});
        tbl.push_back('{0, 32'h18, 32'h0, 32'h0});
        tbl.push_back('{1, 32'h08, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{0, 32'h08, 32'h0, 32'h0FFF_0FFF});
        tbl.push_back('{1, 32'h0C, 32'h1234_56A5, 32'h0});
        tbl.push_back('{0, 32'h0C, 32'h0, 32'hA5});
        tbl.push_back('{1, 32'h00, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{0, 32'h00, 32'h0, ID});
        tbl.push_back('{1, 32'h40, 32'h1111_1111, 32'h0});
        tbl.push_back('{0, 32'h40, 32'h0, 32'h0});
        tbl.push_back('{0, 32'h1C, 32'h0, 32'h0});
        tbl.push_back('{1, 32'hABCD_0108, 32'h0010_0020, 32'h0});
        tbl.push_back('{0, 32'h08, 32'h0, 32'h0010_0020});

        repeat (3) @(negedge reg_cpu_clk);
        rst = 0;
        @(negedge reg_cpu_clk);
        chk("rst_wack", bus.reg_cpu_wack, 0);
        chk("rst_rdv", bus.reg_cpu_rdv, 0);
        chk("rst_data_rd", bus.reg_cpu_data_rd, 0);
        chk("rst_start", cfg_start, 0);
        chk("rst_irq", irq, 0);
        chk("rst_enable", cfg_enable, 0);
        chk("rst_width", cfg_width, 12'd640);
        chk("rst_height", cfg_height, 12'd480);
        chk("rst_thresh", cfg_thresh, 8'h80);

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, 0, 0);
                chk_wack($sformatf("tbl%0d", i));
            end else begin
                do_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rd", i));
            end
        end
        chk("tbl_width", cfg_width, 12'h020);
        chk("tbl_height", cfg_height, 12'h010);
        chk("tbl_thresh", cfg_thresh, 8'hA5);

        do_write(32'h08, 32'h0123_0456, 0, 0);
        chk_wack("size");
        chk("size_width", cfg_width, 12'h456);
        chk("size_height", cfg_height, 12'h123);
        do_read(32'h08, 32'h0123_0456, "size_rd");

        do_write(32'h04, 32'h3, 0, 0);
        chk_wack("ctrl");
        chk("ctrl_start_cnt", s_cnt, 1);
        chk("ctrl_enable", cfg_enable, 1);
        do_read(32'h04, 32'h1, "ctrl_rd");
        do_write(32'h04, 32'h1, 0, 0);
        chk("ctrl_nostart", s_cnt, 0);

        // we and re together behave as a write only
        do_write(32'h0C, 32'h5A, 0, 1);
        chk_wack("wr_re");
        chk("wr_re_no_rdv", r_cnt, 0);
        chk("wr_re_thresh", cfg_thresh, 8'h5A);

        // a write presented while a read is in flight is dropped
        @(negedge reg_cpu_clk);
        bus.reg_cpu_cs = 1; bus.reg_cpu_re = 1; bus.reg_cpu_addr = 32'h0C;
        @(posedge reg_cpu_clk);
        #1 bus.reg_cpu_re = 0; bus.reg_cpu_we = 1; bus.reg_cpu_data_wr = 32'h11;
        @(posedge reg_cpu_clk);
        #1 bus.reg_cpu_cs = 0; bus.reg_cpu_we = 0;
        @(negedge reg_cpu_clk);
        chk("busy_rdv", bus.reg_cpu_rdv, 1);
        chk("busy_rd", bus.reg_cpu_data_rd, 32'h5A);
        @(negedge reg_cpu_clk);
        chk("busy_no_wack", bus.reg_cpu_wack, 0);
        chk("busy_thresh", cfg_thresh, 8'h5A);

        do_write(32'h14, 32'h1, 0, 0);
        chk_wack("irqen");
        do_read(32'h14, 32'h1, "irqen_rd");
        @(negedge reg_cpu_clk);
        pipe_done = 1;
        @(posedge reg_cpu_clk);
        #1 pipe_done = 0;
        @(negedge reg_cpu_clk);
        chk("irq_lat0", irq, 0);
        @(negedge reg_cpu_clk);
        chk("irq_set", irq, 1);
        do_read(32'h10, 32'h2, "status_done");
        pipe_busy = 1;
        do_read(32'h10, 32'h3, "status_busy");
        pipe_busy = 0;
        do_write(32'h10, 32'h2, 0, 0);
        chk_wack("w1c");
        chk("irq_clr", irq, 0);
        do_read(32'h10, 32'h0, "status_clr");

        do_read(32'h18, 32'h1, "fcnt_one");
        do_write(32'h18, 32'h5555, 0, 0);
        do_read(32'h18, 32'h0, "fcnt_clr");
        @(negedge reg_cpu_clk);
        pipe_done = 1;
        repeat (65537) @(negedge reg_cpu_clk);
        pipe_done = 0;
        do_read(32'h18, 32'h1, "fcnt_wrap");
        do_write(32'h18, 32'h0, 1, 0);
        do_read(32'h18, 32'h1, "fcnt_wr_done");
        do_write(32'h10, 32'h2, 1, 0);
        do_read(32'h10, 32'h2, "w1c_vs_done");

        // reset while a read sits in RD_WAIT
        @(negedge reg_cpu_clk);
        bus.reg_cpu_cs = 1; bus.reg_cpu_re = 1; bus.reg_cpu_addr = 32'h00;
        @(posedge reg_cpu_clk);
        #1 bus.reg_cpu_cs = 0; bus.reg_cpu_re = 0;
        #1 rst = 1;
        #2 rst = 0;
        r_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge reg_cpu_clk);
            r_cnt += int'(bus.reg_cpu_rdv);
        end
        chk("abort_no_rdv", r_cnt, 0);
        chk("abort_enable", cfg_enable, 0);
        chk("abort_width", cfg_width, 12'd640);
        chk("abort_height", cfg_height, 12'd480);
        chk("abort_thresh", cfg_thresh, 8'h80);
        chk("abort_irq", irq, 0);
        do_read(32'h10, 32'h0, "abort_status");
        do_read(32'h18, 32'h0, "abort_fcnt");
        do_read(32'h14, 32'h0, "abort_irqen");

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
